// File: rtl/div_pkg.sv
// Shared constants for the iterative divider: FSM states, handshake levels,
// result width and the ALU op codes that select DIV / DIVU in EX.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam int REG_W        = 32;
    localparam int DOUBLE_REG_W = 2 * REG_W;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU. One quotient bit per cycle over
// DATA_W cycles, then one fix-up cycle that restores the signs. Result is
// {remainder, quotient}, held with ready_o until EX drops start_i.
module div
    import div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    div_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem_r;      // partial remainder
    logic [DATA_W-1:0] quo_r;      // dividend shifting out / quotient shifting in
    logic [DATA_W-1:0] divisor_r;
    logic              sdiv_r;
    logic              s1_r;
    logic              s2_r;

    // Operand magnitudes: signed ops divide |op1| by |op2|, signs fixed at the end.
    logic [DATA_W-1:0] op1_abs;
    logic [DATA_W-1:0] op2_abs;
    assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // Shifted remainder needs DATA_W+1 bits: rem < divisor can still have its MSB
    // set for unsigned divisors near 2^DATA_W, and the shift must not drop it.
    logic [DATA_W:0]   part_hi;
    logic [DATA_W+1:0] trial;
    logic              no_borrow;
    logic [DATA_W-1:0] rem_nx;
    logic [DATA_W-1:0] quo_nx;
    assign part_hi   = {rem_r, quo_r[DATA_W-1]};
    assign trial     = {1'b0, part_hi} - {2'b00, divisor_r};
    assign no_borrow = ~trial[DATA_W+1];
    assign rem_nx    = no_borrow ? trial[DATA_W-1:0] : part_hi[DATA_W-1:0];
    assign quo_nx    = {quo_r[DATA_W-2:0], no_borrow};

    // Sign fix-up: quotient negative when signs differ, remainder follows dividend.
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;
    assign quo_fix = (sdiv_r && (s1_r ^ s2_r)) ? -quo_r : quo_r;
    assign rem_fix = (sdiv_r && s1_r) ? -rem_r : rem_r;

    // Controller and datapath registers in one FSM; outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= DIV_FREE;
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            divisor_r <= '0;
            sdiv_r    <= 1'b0;
            s1_r      <= 1'b0;
            s2_r      <= 1'b0;
            result_o  <= '0;
            ready_o   <= DIV_RESULT_NOT_READY;
        end else begin
            case (state)
                DIV_FREE: begin
                    result_o <= '0;
                    ready_o  <= DIV_RESULT_NOT_READY;
                    // annul wins over a simultaneous start
                    if (start_i == DIV_START && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= DIV_BY_ZERO;
                        end else begin
                            state     <= DIV_ON;
                            cnt       <= '0;
                            rem_r     <= '0;
                            quo_r     <= op1_abs;
                            divisor_r <= op2_abs;
                            sdiv_r    <= signed_div_i;
                            s1_r      <= opdata1_i[DATA_W-1];
                            s2_r      <= opdata2_i[DATA_W-1];
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    if (annul_i) begin
                        state <= DIV_FREE;
                    end else begin
                        state    <= DIV_END;
                        result_o <= '0;
                        ready_o  <= DIV_RESULT_READY;
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state   <= DIV_FREE;
                        cnt     <= '0;
                        ready_o <= DIV_RESULT_NOT_READY;
                    end else if (cnt != CNT_W'(DATA_W)) begin
                        rem_r <= rem_nx;
                        quo_r <= quo_nx;
                        cnt   <= cnt + CNT_W'(1);
                    end else begin
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= DIV_RESULT_READY;
                        state    <= DIV_END;
                        cnt      <= '0;
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        state    <= DIV_FREE;
                        result_o <= '0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Bench for the iterative divider: directed corner cases plus random operands,
// checked against a plain-arithmetic reference on 64-bit integers.
module tb_div;
    import div_pkg::*;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks   = 0;
    int failures = 0;

    div #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: truncating division on 64-bit integers; x/0 yields 0.
    function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        return {r[31:0], q[31:0]};
    endfunction

    // Counts edges from acceptance (E0) to the edge after which ready_o is seen.
    // Operand inputs are scrambled after E0 to show they are not re-sampled.
    task automatic wait_ready(output int edges);
        edges = 0;
        while (1) begin
            @(posedge clk);
            #1;
            if (edges == 0) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom);
            end
            if (ready_o) break;
            edges++;
            if (edges > 100) break;
        end
    endtask

    task automatic do_div(input bit sg, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        int          edges;
        int          lat;
        exp = ref_div(sg, a, b);
        lat = (b == 32'd0) ? 1 : 33;
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        wait_ready(edges);
        check({tag, " latency"}, 64'(edges), 64'(lat));
        check({tag, " result"}, result_o, exp);
        @(posedge clk); #1;
        check({tag, " hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
        start_i = 1'b0;
        @(posedge clk); #1;
        check({tag, " release"}, {63'd0, ready_o}, 64'd0);
        check({tag, " release result"}, result_o, 64'd0);
    endtask

    initial begin
        int          edges;
        bit          seen;
        bit          sg;
        logic [31:0] a;
        logic [31:0] b;

        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
        signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        #12;
        check("reset ready", {63'd0, ready_o}, 64'd0);
        check("reset result", result_o, 64'd0);
        check("reset state", {62'd0, dut.state}, {62'd0, DIV_FREE});
        rst = 1'b1;
        @(posedge clk); #1;

        do_div(1'b0, 32'd100, 32'd7, "divu 100/7");
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div 7/-2");
        do_div(1'b0, 32'd1234, 32'd0, "div by zero");
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "signed overflow");
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu max/1");
        do_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "divu big divisor");
        do_div(1'b1, 32'h8000_0000, 32'h8000_0000, "div min/min");

        // Flush after 10 iterations: no result may ever appear.
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        annul_i = 1'b0;
        check("annul state", {62'd0, dut.state}, {62'd0, DIV_FREE});
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o) seen = 1'b1;
        end
        check("annul no ready", {63'd0, seen}, 64'd0);
        do_div(1'b0, 32'd9, 32'd3, "after annul 9/3");

        // start and annul together in FREE: annul wins.
        opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("start+annul state", {62'd0, dut.state}, {62'd0, DIV_FREE});
        check("start+annul ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0; annul_i = 1'b0;
        @(posedge clk); #1;

        // Async reset in the middle of an iteration, between edges.
        opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst mid-on state", {62'd0, dut.state}, {62'd0, DIV_FREE});
        check("rst mid-on out", {ready_o, result_o[62:0]}, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Async reset while a result is being held.
        signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
        wait_ready(edges);
        check("pre-rst result", result_o, {32'd2, 32'd15});
        #2;
        rst = 1'b0;
        #1;
        check("rst in end out", {ready_o, result_o[62:0]}, 64'd0);
        check("rst in end hi", {63'd0, result_o[63]}, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Random operands, biased toward small divisors and zero.
        for (int i = 0; i < 20; i++) begin
            sg = 1'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            do_div(sg, a, b, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle iterative divider controller and datapath that sequences DIV/DIVU for the EX stage.
- EX raises a start request with operands. The block runs a radix-2 restoring division over 32 iterations and returns {remainder, quotient} with a ready flag.
- While busy, EX holds stallreq_from_ex so ctrl freezes the pipeline.
- The result feeds HI (remainder) and LO (quotient) through the existing whilo path.

Parameters:
- DATA_W, 32, operand width (`RegBus). Iteration count equals DATA_W. The counter is clog2(DATA_W)+1 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  DATA_W  dividend
- opdata2_i  in  DATA_W  divisor
- start_i  in  1  division request; EX holds it high until ready_o is seen
- annul_i  in  1  abort the in-flight division (pipeline flush)
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}; registered
- ready_o  out  1  result valid; registered

Behaviour:
- Reset (rst=0, async): state=FREE, cnt=0, result_o=0, ready_o=0, internal dividend/divisor registers=0.
- States: FREE, BY_ZERO, ON, END (encoded 2 bits).
- FREE:
  - start_i=1 and annul_i=0 and opdata2_i==0 -> BY_ZERO.
  - start_i=1 and annul_i=0 and opdata2_i!=0 -> ON, cnt=0. Latch |op1| and |op2| when signed_div_i=1 (two's-complement negate if MSB set); otherwise latch raw values.
  - Also latch signed_div_i, op1 sign and op2 sign for fix-up. Partial remainder cleared.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- ON:
  - annul_i=1 -> FREE next edge, ready_o stays 0, no result.
  - cnt<DATA_W: one restoring iteration per cycle. Shift {rem,quo} left by 1, compute trial = rem_hi - divisor. If trial does not borrow, rem_hi=trial and quo LSB=1; else quo LSB=0. Then cnt++.
  - cnt==DATA_W: apply sign fix-up (signed only). Negate quotient if dividend sign != divisor sign. Remainder takes the dividend sign.
  - Also on cnt==DATA_W: register result_o, set ready_o=1, go to END, cnt=0.
- BY_ZERO:
  - annul_i=1 -> FREE.
  - Else next edge -> END with result_o=0 and ready_o=1.
- END:
  - Hold result_o and ready_o=1 while start_i=1.
  - start_i=0 -> FREE next edge, with ready_o=0 and result_o=0.
  - annul_i is ignored in END.
- Latency, counting the accepting edge as E0:
  - Normal division: ready_o rises after edge E33 (32 iterations plus 1 fix-up edge).
  - Divide-by-zero: ready_o rises after edge E1.
- Operands are sampled only in FREE. Changes to opdata*_i during ON/END have no effect.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient wraps to 0x80000000, remainder 0. No exception is raised.
- start_i and annul_i asserted together in FREE: annul wins, stay in FREE.
- Async reset mid-operation: immediate return to reset values, no partial result visible.
- EX contract (informative for integration):
  - stallreq = start asserted and ready_o=0.
  - EX drops start_i in the cycle after consuming ready_o.

Decomposition:
- define.v (shared) adds:
  - Div state constants DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
  - DivResultReady/DivResultNotReady and DivStart/DivStop.
  - `DoubleRegBus for result width.
  - EXE_DIV_OP and EXE_DIVU_OP aluop codes.
- Single module, no sub-module. Abs/negate fix-up and the subtract-compare are inline combinational logic.

Test Plan:
- DIVU 100/7, start held -> ready_o=1 exactly 33 edges after acceptance, result_o={32'd2, 32'd14}. Drop start -> next edge ready_o=0, result_o=0.
- DIV -7/2 (0xFFFFFFF9 / 2) -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Also 7/-2 -> q=-3, r=1.
- Divide by zero, op2=0 -> ready_o=1 two edges after start, result_o=64'd0.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0. DIVU 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
- annul_i pulsed at iteration 10 -> FREE next edge, ready_o never rises. A new start of 9/3 -> {0,3} after 33 edges.
- rst driven low mid-ON (async, between edges) -> outputs immediately 0, state FREE. start_i+annul_i together in FREE -> stays FREE.
